// File: rtl/se_gap_pkg.sv
// Shared constants, state encoding and helpers for the SE squeeze stage.
package se_gap_pkg;

    localparam int DW         = 14;
    localparam int FBITS      = 9;
    localparam int IN_BURST   = 16;
    localparam int MAX_GROUPS = 60;
    localparam int CNT_W      = 14;
    localparam int GRP_W      = 6;
    localparam int ACC_W      = DW + CNT_W;
    localparam int RECIP_W    = 24;

    localparam int SAT_MAX = (1 << (DW - 1)) - 1;
    localparam int SAT_MIN = -(1 << (DW - 1));

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACCUM = 3'd1,
        S_SCALE = 3'd2,
        S_OUT   = 3'd3,
        S_FIN   = 3'd4
    } state_e;

    typedef logic [IN_BURST*DW-1:0] beat_t;

    function automatic logic signed [DW-1:0] lane_of(input beat_t v,
                                                     input int i);
        return v[i*DW +: DW];
    endfunction

endpackage

// File: rtl/se_gap_scale_lane.sv
// One lane of the average: acc * recip, round half up, saturate.
module se_gap_scale_lane #(
    parameter int DW      = 14,
    parameter int ACC_W   = 28,
    parameter int RECIP_W = 24
) (
    input  logic signed [ACC_W-1:0]   acc_i,
    input  logic        [RECIP_W-1:0] recip_i,
    output logic signed [DW-1:0]      avg_o
);

    localparam int PW = ACC_W + RECIP_W + 1;

    localparam logic signed [PW-1:0] HALF  = PW'(1) << (RECIP_W - 1);
    localparam logic signed [PW-1:0] MAX_V = PW'((1 << (DW - 1)) - 1);
    localparam logic signed [PW-1:0] MIN_V = PW'(-(1 << (DW - 1)));

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] r_ext;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] rnd;
    logic signed [PW-1:0] shf;

    always_comb begin
        a_ext = {{(PW-ACC_W){acc_i[ACC_W-1]}}, acc_i};
        r_ext = {{(PW-RECIP_W){1'b0}}, recip_i};
        prod  = a_ext * r_ext;
        rnd   = prod + HALF;
        shf   = rnd >>> RECIP_W;
        if (shf > MAX_V) begin
            avg_o = MAX_V[DW-1:0];
        end else if (shf < MIN_V) begin
            avg_o = MIN_V[DW-1:0];
        end else begin
            avg_o = shf[DW-1:0];
        end
    end

endmodule

// File: rtl/se_gap_accum_scaler.sv
// SE squeeze stage: per-channel pooling over a window, then reciprocal
// scaling, one IN_Burst-wide averaged vector per channel group.
module se_gap_accum_scaler
    import se_gap_pkg::*;
#(
    parameter int Data_Width = DW,
    parameter int FBITS_P    = FBITS,
    parameter int IN_Burst   = IN_BURST,
    parameter int MAX_GRP    = MAX_GROUPS,
    parameter int ACC_WP     = Data_Width + CNT_W,
    parameter int RECIP_WP   = RECIP_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [CNT_W-1:0]               window_size,
    input  logic [GRP_W-1:0]               num_groups,
    input  logic [RECIP_WP-1:0]            recip,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [IN_Burst*Data_Width-1:0] in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [IN_Burst*Data_Width-1:0] out_data,
    output logic [GRP_W-1:0]               out_group,
    output logic                           busy,
    output logic                           done
);

    state_e state_q, state_d;

    logic [CNT_W-1:0]    pix_q, pix_d;
    logic [GRP_W-1:0]    grp_q, grp_d;
    logic [CNT_W-1:0]    win_q;
    logic [GRP_W-1:0]    ng_q;
    logic [RECIP_WP-1:0] recip_q;
    logic                cfg_ld;
    logic                beat;
    logic                last_grp;
    logic                last_pix;

    logic [IN_Burst*Data_Width-1:0] out_data_q;
    logic [GRP_W-1:0]               out_group_q;
    logic [IN_Burst*Data_Width-1:0] scaled;

    logic signed [ACC_WP-1:0] acc_q [MAX_GRP][IN_Burst];
    logic signed [ACC_WP-1:0] ext_w [IN_Burst];

    assign beat     = in_valid && (state_q == S_ACCUM);
    assign last_grp = (grp_q == ng_q - GRP_W'(1));
    assign last_pix = (pix_q == win_q - CNT_W'(1));

    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        grp_d   = grp_q;
        cfg_ld  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cfg_ld = 1'b1;
                    pix_d  = '0;
                    grp_d  = '0;
                    if (window_size == '0 || num_groups == '0) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                if (beat) begin
                    if (last_grp) begin
                        grp_d = '0;
                        pix_d = pix_q + CNT_W'(1);
                        if (last_pix) begin
                            state_d = S_SCALE;
                        end
                    end else begin
                        grp_d = grp_q + GRP_W'(1);
                    end
                end
            end
            S_SCALE: state_d = S_OUT;
            S_OUT: begin
                if (out_ready) begin
                    if (last_grp) begin
                        state_d = S_FIN;
                    end else begin
                        grp_d   = grp_q + GRP_W'(1);
                        state_d = S_SCALE;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pix_q       <= '0;
            grp_q       <= '0;
            win_q       <= '0;
            ng_q        <= '0;
            recip_q     <= '0;
            out_data_q  <= '0;
            out_group_q <= '0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            grp_q   <= grp_d;
            if (cfg_ld) begin
                win_q   <= window_size;
                ng_q    <= num_groups;
                recip_q <= recip;
            end
            if (state_q == S_SCALE) begin
                out_data_q  <= scaled;
                out_group_q <= grp_q;
            end
        end
    end

    for (genvar l = 0; l < IN_Burst; l++) begin : g_lane
        assign ext_w[l] = {{(ACC_WP-Data_Width){in_data[l*Data_Width+Data_Width-1]}},
                           in_data[l*Data_Width +: Data_Width]};

        se_gap_scale_lane #(
            .DW      (Data_Width),
            .ACC_W   (ACC_WP),
            .RECIP_W (RECIP_WP)
        ) u_lane (
            .acc_i   (acc_q[grp_q][l]),
            .recip_i (recip_q),
            .avg_o   (scaled[l*Data_Width +: Data_Width])
        );
    end

    // First pixel of a layer overwrites, so no clearing pass is needed.
    always_ff @(posedge clk) begin
        if (beat) begin
            for (int l = 0; l < IN_Burst; l++) begin
                if (pix_q == '0) begin
                    acc_q[grp_q][l] <= ext_w[l];
                end else begin
                    acc_q[grp_q][l] <= acc_q[grp_q][l] + ext_w[l];
                end
            end
        end
    end

    assign in_ready  = (state_q == S_ACCUM);
    assign out_valid = (state_q == S_OUT);
    assign busy      = (state_q == S_ACCUM) || (state_q == S_SCALE) ||
                       (state_q == S_OUT);
    assign done      = (state_q == S_FIN);
    assign out_data  = out_data_q;
    assign out_group = out_group_q;

endmodule
